// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Unsigned shift-add multiplier that handles one multiplier bit per clock.
//   It uses the same Run/Rdy handshake as the restoring divider, so the
//   control layer can drive both units in the same way.
//
//   Ports:
//     clk     - single clock; all state changes on the rising edge
//     Rst     - asynchronous active-low reset
//     Run     - start request, sampled on the rising edge (ignored in CALC)
//     Mcand   - multiplicand, WIDTH bits unsigned
//     Mplier  - multiplier, WIDTH bits unsigned
//     Hi, Lo  - upper and lower halves of the 2*WIDTH product register
//     Rdy     - registered; high while Hi/Lo hold a completed product
//
//   If Run is sampled at edge N, Rdy rises at edge N+WIDTH.
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             Run,
    input  logic [WIDTH-1:0] Mcand,
    input  logic [WIDTH-1:0] Mplier,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Rdy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             rdy_q,   rdy_d;

    // The add is WIDTH+1 bits wide so that the carry survives. The right
    // shift then moves the carry into Hi[WIDTH-1].
    logic [WIDTH:0]   sum;

    always_comb begin
        if (lo_q[0]) begin
            sum = {1'b0, hi_q} + {1'b0, mcand_q};
        end else begin
            sum = {1'b0, hi_q};
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE.
                // Without Run, the completed product and Rdy stay as they are.
                if (Run) begin
                    mcand_d = Mcand;
                    hi_d    = '0;
                    lo_d    = Mplier;
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                    state_d = CALC;
                end
            end

            CALC: begin
                // Run is ignored here, and the operand inputs were already
                // captured at the load edge.
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                rdy_d   = 1'b0;
            end
        endcase
    end

    assign Hi  = hi_q;
    assign Lo  = lo_q;
    assign Rdy = rdy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed bench for seq_multiplier (WIDTH=32). A table of operand pairs
//   with hand-computed products is run in a loop. Hand-written sequences then
//   cover Run held high, reset in the middle of CALC, and restart from DONE.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         Rst;
    logic         Run;
    logic [W-1:0] Mcand;
    logic [W-1:0] Mplier;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         Rdy;

    int total = 0;
    int bad   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk    (clk),
        .Rst    (Rst),
        .Run    (Run),
        .Mcand  (Mcand),
        .Mplier (Mplier),
        .Hi     (Hi),
        .Lo     (Lo),
        .Rdy    (Rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mcand;
        logic [W-1:0] mplier;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Count edges from the load edge until Rdy rises, with a fixed bound.
    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!Rdy && n < 40);
        chk({name, " latency"}, 64'(n), 64'd32);
    endtask

    // Load the operands on one edge with a single-cycle Run pulse, then check
    // that Rdy drops, the latency, and the product.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        @(negedge clk);
        Mcand  = a;
        Mplier = b;
        Run    = 1'b1;
        @(posedge clk);
        #1;
        Run    = 1'b0;
        Mcand  = ~a;
        Mplier = ~b;
        chk({name, " rdy low after load"}, 64'(Rdy), 64'd0);
        wait_rdy(name);
        chk({name, " hi"}, 64'(Hi), 64'(eh));
        chk({name, " lo"}, 64'(Lo), 64'(el));
    endtask

    initial begin
        vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'd0,        32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};
        vecs[4] = '{32'hDEAD_BEEF, 32'h10,       32'h0000_000D, 32'hEADB_EEF0};
        vecs[5] = '{32'd6,        32'd7,        32'h0000_0000, 32'd42};

        Rst    = 1'b0;
        Run    = 1'b0;
        Mcand  = '0;
        Mplier = '0;
        #12;
        chk("reset hi",  64'(Hi),  64'd0);
        chk("reset lo",  64'(Lo),  64'd0);
        chk("reset rdy", 64'(Rdy), 64'd0);
        @(negedge clk);
        Rst = 1'b1;

        // The vectors run back to back. From the second one on, each starts
        // from DONE.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mcand, vecs[i].mplier, vecs[i].hi, vecs[i].lo);
        end

        // DONE holds its value while Run stays low.
        repeat (5) @(posedge clk);
        #1;
        chk("done hold rdy", 64'(Rdy), 64'd1);
        chk("done hold lo",  64'(Lo),  64'd42);

        // Run held high. The operands change during CALC, and neither the
        // change nor Run may disturb the computation.
        @(negedge clk);
        Mcand  = 32'h0001_0000;
        Mplier = 32'h0001_0000;
        Run    = 1'b1;
        @(posedge clk);
        #1;
        Mcand  = 32'd7;
        Mplier = 32'd7;
        chk("held rdy low after load", 64'(Rdy), 64'd0);
        wait_rdy("held");
        chk("held hi", 64'(Hi), 64'd1);
        chk("held lo", 64'(Lo), 64'd0);
        // Run is still high in DONE, so the next edge restarts with 7*7.
        @(posedge clk);
        #1;
        Run = 1'b0;
        chk("held restart rdy low", 64'(Rdy), 64'd0);
        wait_rdy("held restart");
        chk("held restart hi", 64'(Hi), 64'd0);
        chk("held restart lo", 64'(Lo), 64'd49);

        // Reset arrives mid-CALC, between clock edges.
        @(negedge clk);
        Mcand  = 32'hFFFF_FFFF;
        Mplier = 32'hFFFF_FFFF;
        Run    = 1'b1;
        @(posedge clk);
        #1;
        Run = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        Rst = 1'b0;
        #1;
        chk("midreset hi",  64'(Hi),  64'd0);
        chk("midreset lo",  64'(Lo),  64'd0);
        chk("midreset rdy", 64'(Rdy), 64'd0);
        @(negedge clk);
        Rst = 1'b1;
        run_op("after reset", 32'd6, 32'd7, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends, even if the DUT misbehaves.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
